// File: rtl/gun_pkg.sv
// gun_pkg: shared types and constants for the gun fire controller.
//   state_t          - controller FSM states
//   KIND_BULLET/BOMB - spawn_kind encodings
//   DIR_*            - gun_dir / spawn_dir encodings
//   max_int          - helper for sizing the shared cycle timer
package gun_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_COOLDOWN = 2'd2,
    ST_RELOAD   = 2'd3
  } state_t;

  localparam logic KIND_BULLET = 1'b0;
  localparam logic KIND_BOMB   = 1'b1;

  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_UP    = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gun_fire_ctrl_cycle_timer.sv
// cycle_timer: loadable down-counter shared by COOLDOWN and RELOAD.
// Ports:
//   clock, reset      - system clock, synchronous active-high reset
//   load, load_val    - load the counter (takes priority over counting)
//   done              - counter is at zero
// The counter decrements every cycle while non-zero and parks at zero.
module cycle_timer
  import gun_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign done = (r_count == '0);

endmodule

// File: rtl/gun_fire_ctrl.sv
// gun_fire_ctrl: turns one-cycle shoot/bomb pulses into rate-limited,
// resource-checked projectile spawn requests (valid/ready).
// Ports:
//   clock, reset            - system clock, synchronous active-high reset
//   gun_dir                 - current aim, captured with each request
//   shooting, bombing       - one-cycle request pulses
//   spawn_valid/spawn_ready - spawn handshake to the projectile engine
//   spawn_dir, spawn_kind   - payload of the pending spawn
//   ammo, bombs             - remaining resources
//   dry_fire                - one-cycle pulse when a request is dropped
//   reloading               - high while in RELOAD
// Build option: define GUN_AUTO_RELOAD_EN to reload the magazine after the
// last bullet; otherwise RELOAD is unreachable and reloading is tied low.
module gun_fire_ctrl
  import gun_pkg::*;
#(
  parameter int COOLDOWN_CYC = 5_000_000,
  parameter int RELOAD_CYC   = 50_000_000,
  parameter int AMMO_MAX     = 8,
  parameter int BOMB_MAX     = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [1:0]                    gun_dir,
  input  logic                          shooting,
  input  logic                          bombing,
  output logic                          spawn_valid,
  input  logic                          spawn_ready,
  output logic [1:0]                    spawn_dir,
  output logic                          spawn_kind,
  output logic [$clog2(AMMO_MAX+1)-1:0] ammo,
  output logic [$clog2(BOMB_MAX+1)-1:0] bombs,
  output logic                          dry_fire,
  output logic                          reloading
);

  localparam int AW = $clog2(AMMO_MAX + 1);
  localparam int BW = $clog2(BOMB_MAX + 1);
  localparam int TW = $clog2(max_int(COOLDOWN_CYC, RELOAD_CYC) + 1);
  localparam logic [AW-1:0] AMMO_FULL = AW'(AMMO_MAX);
  localparam logic [BW-1:0] BOMB_FULL = BW'(BOMB_MAX);
  localparam logic [TW-1:0] T_COOL    = TW'(COOLDOWN_CYC - 1);
`ifdef GUN_AUTO_RELOAD_EN
  localparam logic [TW-1:0] T_RELOAD  = TW'(RELOAD_CYC - 1);
`endif

  function automatic logic [AW-1:0] sat_dec_ammo(input logic [AW-1:0] v);
    return (v == '0) ? v : v - AW'(1);
  endfunction

  function automatic logic [BW-1:0] sat_dec_bombs(input logic [BW-1:0] v);
    return (v == '0) ? v : v - BW'(1);
  endfunction

  state_t          r_state, w_state_nxt;
  logic            r_pend_vld, r_pend_kind;
  logic [1:0]      r_pend_dir;
  logic [1:0]      r_spawn_dir;
  logic            r_spawn_kind;
  logic [AW-1:0]   r_ammo;
  logic [BW-1:0]   r_bombs;
  logic            r_dry;
  logic            w_have, w_issue_start, w_dry, w_xfer;
  logic            w_tmr_load, w_tmr_done, w_reload_done, w_consume;
  logic [TW-1:0]   w_tmr_val;

  cycle_timer #(.W(TW)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (w_tmr_load),
    .load_val (w_tmr_val),
    .done     (w_tmr_done)
  );

  assign w_have = (r_pend_kind == KIND_BOMB) ? (r_bombs != '0) : (r_ammo != '0);

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Pending requests are only served from IDLE, so a request captured during
  // COOLDOWN/RELOAD launches one cycle after the exit back to IDLE.
  always_comb begin
    w_state_nxt   = r_state;
    w_issue_start = 1'b0;
    w_dry         = 1'b0;
    w_xfer        = 1'b0;
    w_tmr_load    = 1'b0;
    w_tmr_val     = '0;
    w_reload_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_pend_vld) begin
          if (w_have) begin
            w_issue_start = 1'b1;
            w_state_nxt   = ST_ISSUE;
          end else begin
            w_dry = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (spawn_ready) begin
          w_xfer      = 1'b1;
          w_tmr_load  = 1'b1;
          w_tmr_val   = T_COOL;
          w_state_nxt = ST_COOLDOWN;
        end
      end
      ST_COOLDOWN: begin
        if (w_tmr_done) begin
`ifdef GUN_AUTO_RELOAD_EN
          if (r_ammo == '0) begin
            w_tmr_load  = 1'b1;
            w_tmr_val   = T_RELOAD;
            w_state_nxt = ST_RELOAD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
`else
          w_state_nxt = ST_IDLE;
`endif
        end
      end
      ST_RELOAD: begin
`ifdef GUN_AUTO_RELOAD_EN
        if (w_tmr_done) begin
          w_reload_done = 1'b1;
          w_state_nxt   = ST_IDLE;
        end
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_consume = w_issue_start | w_dry;

  // One-deep request slot: a bomb always lands (overwriting a shoot); a shoot
  // only lands in a slot that is empty or being drained this cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pend_vld  <= 1'b0;
      r_pend_kind <= KIND_BULLET;
      r_pend_dir  <= DIR_RIGHT;
    end else if (bombing) begin
      r_pend_vld  <= 1'b1;
      r_pend_kind <= KIND_BOMB;
      r_pend_dir  <= gun_dir;
    end else if (shooting && (!r_pend_vld || w_consume)) begin
      r_pend_vld  <= 1'b1;
      r_pend_kind <= KIND_BULLET;
      r_pend_dir  <= gun_dir;
    end else if (w_consume) begin
      r_pend_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_spawn_dir  <= DIR_RIGHT;
      r_spawn_kind <= KIND_BULLET;
      r_ammo       <= AMMO_FULL;
      r_bombs      <= BOMB_FULL;
      r_dry        <= 1'b0;
    end else begin
      r_dry <= w_dry;
      if (w_issue_start) begin
        r_spawn_dir  <= r_pend_dir;
        r_spawn_kind <= r_pend_kind;
      end
      if (w_xfer && r_spawn_kind == KIND_BULLET) r_ammo <= sat_dec_ammo(r_ammo);
      else if (w_reload_done)                    r_ammo <= AMMO_FULL;
      if (w_xfer && r_spawn_kind == KIND_BOMB)   r_bombs <= sat_dec_bombs(r_bombs);
    end
  end

  assign spawn_valid = (r_state == ST_ISSUE);
  assign spawn_dir   = r_spawn_dir;
  assign spawn_kind  = r_spawn_kind;
  assign ammo        = r_ammo;
  assign bombs       = r_bombs;
  assign dry_fire    = r_dry;
`ifdef GUN_AUTO_RELOAD_EN
  assign reloading   = (r_state == ST_RELOAD);
`else
  assign reloading   = 1'b0;
`endif

endmodule

// File: doc/gun_fire_ctrl.md
# gun_fire_ctrl

Downstream consumer of the PS/2 keyboard decoder's `gun_dir`, `shooting` and `bombing` outputs. It turns one-cycle fire/bomb pulses into rate-limited, resource-checked projectile spawn requests for the projectile engine. Spawn requests use a valid/ready handshake. The block also tracks ammo and bombs, enforces a cooldown between shots, and optionally auto-reloads.

## Interface
Parameters:
- `COOLDOWN_CYC`, default 5_000_000: cycles between accepted spawns (100 ms at 50 MHz); must be ≥1.
- `RELOAD_CYC`, default 50_000_000: reload duration in cycles; must be ≥1.
- `AMMO_MAX`, default 8: bullets per magazine; must be ≥1.
- `BOMB_MAX`, default 3: bombs per game; never replenished.

Ports:
- `clock`  in  1: 50 MHz system clock. One clock domain only.
- `reset`  in  1: synchronous, active-high reset.
- `gun_dir`  in  2: current aim (00 right, 01 up, 10 left, 11 down).
- `shooting`  in  1: one-cycle shoot request pulse.
- `bombing`  in  1: one-cycle bomb request pulse.
- `spawn_valid`  out  1: spawn request pending.
- `spawn_ready`  in  1: projectile engine accepts the spawn.
- `spawn_dir`  out  2: direction of the pending spawn.
- `spawn_kind`  out  1: 0 = bullet, 1 = bomb.
- `ammo`  out  $clog2(AMMO_MAX+1): bullets remaining.
- `bombs`  out  $clog2(BOMB_MAX+1): bombs remaining.
- `dry_fire`  out  1: one-cycle pulse when a request is dropped for lack of a resource.
- `reloading`  out  1: high while in RELOAD.

## Operation
- States: IDLE, ISSUE, COOLDOWN, RELOAD.
- Request capture:
  - A `shooting` or `bombing` pulse, together with `gun_dir`, is registered into a one-deep pending slot on the edge where the pulse is seen.
  - If both pulse in the same cycle, bomb wins and the shoot is discarded.
  - A bomb overwrites a pending shoot. A shoot never overwrites a pending bomb.
  - Further shoots while a shoot is already pending are discarded.
- IDLE, or exit from COOLDOWN/RELOAD with a pending request: check the resource (ammo>0 for a bullet, bombs>0 for a bomb).
  - Resource available: enter ISSUE and drive `spawn_dir`/`spawn_kind` from the slot. The slot clears.
  - Resource absent: pulse `dry_fire`, clear the slot, stay in or return to IDLE.
- ISSUE:
  - `spawn_valid`=1, with dir and kind held stable until `spawn_valid & spawn_ready`.
  - On transfer, decrement `ammo` or `bombs` and enter COOLDOWN with the timer loaded to COOLDOWN_CYC−1.
- COOLDOWN: the timer counts to 0, then go to RELOAD if the reload condition (see Configuration) holds; otherwise IDLE.
- RELOAD:
  - `reloading`=1 for RELOAD_CYC cycles, then `ammo`←AMMO_MAX and go to IDLE.
  - Requests arriving in COOLDOWN or RELOAD are captured per the rules above and served on exit.
- Counters saturate; no wrap-around. `ammo` never goes below 0 or above AMMO_MAX.
- Reset (at any state, including mid-handshake):
  - State IDLE, `spawn_valid`=0, `spawn_dir`=00, `spawn_kind`=0.
  - `ammo`=AMMO_MAX, `bombs`=BOMB_MAX.
  - `dry_fire`=0, `reloading`=0, slot empty, timer 0.

## Timing
- Pulse at edge N, state IDLE: `spawn_valid`=1 after edge N+1 (one-cycle latency).
- Transfer at edge T: `spawn_valid`=0 and the count is decremented after T.
- COOLDOWN occupies edges T+1…T+COOLDOWN_CYC.
- A pending request gives `spawn_valid` again after edge T+COOLDOWN_CYC+1.
- `dry_fire` is asserted for exactly one cycle, on the cycle after the resource check.
- `spawn_ready` is ignored when `spawn_valid`=0.
- `spawn_valid` never deasserts without a transfer, except on reset.

## Configuration
- `GUN_AUTO_RELOAD_EN` defined: when `ammo` reaches 0 after a transfer, COOLDOWN exits to RELOAD.
- `GUN_AUTO_RELOAD_EN` undefined:
  - RELOAD is unreachable and `reloading` is tied 0.
  - Once `ammo`=0, every shoot gives `dry_fire` until reset.
- Bombs are unaffected either way.

## Structure
- Package `gun_pkg`:
  - state enum.
  - `KIND_BULLET`/`KIND_BOMB` constants.
  - direction encodings `DIR_RIGHT`=00, `DIR_UP`=01, `DIR_LEFT`=10, `DIR_DOWN`=11.
- Sub-module `cycle_timer`: load/count-down/`done` timer. One instance is shared by COOLDOWN and RELOAD, width $clog2(max(COOLDOWN_CYC,RELOAD_CYC)+1).

## Test plan
Bench parameters: COOLDOWN_CYC=4, RELOAD_CYC=10, AMMO_MAX=3, BOMB_MAX=1, `spawn_ready`=1 unless stated.
- Shoot pulse, `gun_dir`=01 → `spawn_valid` next cycle, dir=01, kind=0, 1-cycle transfer, `ammo` 3→2.
- `spawn_ready` held 0 for 5 cycles → `spawn_valid`, dir and kind stable throughout; transfer on cycle 6; `ammo` decrements once.
- Shoot and bomb in the same cycle → a single spawn with kind=1, `bombs` 1→0. A second bomb → `dry_fire` pulse, no spawn.
- Shoot twice, 1 cycle apart → second spawn `spawn_valid` exactly 5 cycles after the first transfer. A third shoot during cooldown is dropped.
- 3 shoots with AUTO_RELOAD_EN → `ammo`=0, `reloading` high for 10 cycles, then `ammo`=3. Without the macro, a 4th shoot → `dry_fire`.
- Reset asserted during ISSUE → next cycle `spawn_valid`=0, `ammo`=3, `bombs`=1, state IDLE.
